// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch stage and its skid buffer.
package mips_pkg;

   typedef enum logic [1:0] {
      F_IDLE,
      F_WAIT,
      F_DROP
   } fetch_state_t;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} holding buffer for a word
// that returned while decode could not take it.
module fetch_skid_buf
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              unload,
   input  logic              flush,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [ADDR_W-1:0] in_pc,
   output logic              full,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   // Entry register: flush beats load, load beats unload.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         full      <= 1'b0;
         out_instr <= DATA_W'(NOP_INSTR);
         out_pc    <= '0;
      end else if (load) begin
         full      <= 1'b1;
         out_instr <= in_instr;
         out_pc    <= in_pc;
      end else if (unload) begin
         full      <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC mux, single-outstanding
// imem handshake FSM and the IF/ID register.
module fetch_stage
   import mips_pkg::*;
#(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_address,
   output logic [ADDR_W-1:0] next_address,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              stall_id,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus4
);

   fetch_state_t      state_q;
   fetch_state_t      state_d;
   logic [ADDR_W-1:0] req_pc;
   logic              id_can;
   logic              ret_fits;
   logic              resp_keep;
   logic              accept;
   logic              skid_full;
   logic              skid_load;
   logic              skid_unload;
   logic [DATA_W-1:0] skid_instr;
   logic [ADDR_W-1:0] skid_pc;

   assign id_can    = !if_valid || !stall_id;
   assign ret_fits  = id_can && !skid_full;
   assign resp_keep = (state_q == F_WAIT) && imem_rvalid
                      && !redirect_valid;
   assign imem_addr = {pc_address[ADDR_W-1:2], 2'b00};

   assign skid_load   = resp_keep && !ret_fits;
   assign skid_unload = id_can && skid_full && !redirect_valid;

   // Request issue, PC steering and FSM next state.
   always_comb begin
      imem_req     = 1'b0;
      accept       = 1'b0;
      next_address = pc_address;
      state_d      = state_q;

      imem_req = !rst && !redirect_valid && !skid_full
                 && ((state_q == F_IDLE)
                     || (imem_rvalid && ret_fits));
      accept   = imem_req && imem_gnt;

      if (rst)
         next_address = RESET_PC;
      else if (redirect_valid)
         next_address = redirect_target;
      else if (accept)
         next_address = pc_address + ADDR_W'(PC_STEP);

      unique case (state_q)
         F_IDLE: begin
            if (accept)
               state_d = F_WAIT;
         end
         F_WAIT: begin
            if (redirect_valid)
               state_d = imem_rvalid ? F_IDLE : F_DROP;
            else if (imem_rvalid)
               state_d = accept ? F_WAIT : F_IDLE;
         end
         F_DROP: begin
            if (imem_rvalid)
               state_d = accept ? F_WAIT : F_IDLE;
         end
         default: state_d = F_IDLE;
      endcase
   end

   // FSM state and address of the outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= F_IDLE;
         req_pc  <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            req_pc <= pc_address;
      end
   end

   // IF/ID register: redirect flushes, skid drains first.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         if_valid    <= 1'b0;
         if_instr    <= DATA_W'(NOP_INSTR);
         if_pc       <= '0;
         if_pc_plus4 <= '0;
      end else if (id_can) begin
         if (skid_full) begin
            if_valid    <= 1'b1;
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus4 <= skid_pc + ADDR_W'(PC_STEP);
         end else if (resp_keep) begin
            if_valid    <= 1'b1;
            if_instr    <= imem_rdata;
            if_pc       <= req_pc;
            if_pc_plus4 <= req_pc + ADDR_W'(PC_STEP);
         end else begin
            if_valid    <= 1'b0;
            if_instr    <= DATA_W'(NOP_INSTR);
            if_pc       <= '0;
            if_pc_plus4 <= '0;
         end
      end
   end

   fetch_skid_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .unload    (skid_unload),
      .flush     (redirect_valid),
      .in_instr  (imem_rdata),
      .in_pc     (req_pc),
      .full      (skid_full),
      .out_instr (skid_instr),
      .out_pc    (skid_pc)
   );

endmodule
